vreg_wb_arbiter: RTL

//  Owns the single write port of the vector register file. Shares it between
//  the pipeline vector writeback (v_write/rD/vwrite_data) and the convolution

---
 rtl/vreg_wb_arbiter_pkg.sv | 23 ++
 rtl/vreg_wb_arbiter_conv_wb_fifo.sv | 63 ++++++
 rtl/vreg_wb_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vreg_wb_arbiter_pkg.sv
// rtl/vreg_wb_arbiter_pkg.sv - shared widths, grant encoding and hazard helper for the vreg write arbiter
package vreg_wb_arbiter_pkg;

  localparam int LENGTH         = 4;
  localparam int INT8           = 8;
  localparam int VW_DEF         = LENGTH * INT8;
  localparam int AW_DEF         = 5;
  localparam int DEPTH_DEF      = 4;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_CONV = 2'd2
  } grant_e;

  // A source only counts when decode actually reads it this cycle.
  function automatic logic src_hit(input logic a_vec, input logic a_eq,
                                   input logic b_vec, input logic b_eq);
    return (a_vec && a_eq) || (b_vec && b_eq);
  endfunction

endpackage

// File: rtl/vreg_wb_arbiter_conv_wb_fifo.sv
// rtl/vreg_wb_arbiter_conv_wb_fifo.sv - circular buffer of pending conv writes with per-entry address taps
module conv_wb_fifo #(
  parameter int AW    = 5,
  parameter int VW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_push,
  input  logic [AW-1:0]                i_addr,
  input  logic [VW-1:0]                i_data,
  input  logic                         i_pop,
  output logic [AW-1:0]                o_head_addr,
  output logic [VW-1:0]                o_head_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic [DEPTH*AW-1:0]          o_entry_addr,
  output logic [DEPTH-1:0]             o_entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW+VW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_off;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= {i_addr, i_data};
  end

  assign o_head_addr = r_mem[r_rptr][AW+VW-1:VW];
  assign o_head_data = r_mem[r_rptr][VW-1:0];
  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    w_off         = '0;
    o_entry_valid = '0;
    o_entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off                    = PW'(i) - r_rptr;
      o_entry_valid[i]         = (CW'(w_off) < r_count);
      o_entry_addr[i*AW +: AW] = r_mem[i][AW+VW-1:VW];
    end
  end

endmodule

// File: rtl/vreg_wb_arbiter.sv
// rtl/vreg_wb_arbiter.sv - vector register file write-port arbiter between pipeline writeback and conv results
module vreg_wb_arbiter
  import vreg_wb_arbiter_pkg::*;
#(
  parameter int VW         = VW_DEF,
  parameter int AW         = AW_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_valid,
  input  logic [AW-1:0]               wb_addr,
  input  logic [VW-1:0]               wb_data,
  input  logic                        conv_valid,
  input  logic [AW-1:0]               conv_addr,
  input  logic [VW-1:0]               conv_data,
  output logic                        conv_ready,
  input  logic [AW-1:0]               src_a_addr,
  input  logic [AW-1:0]               src_b_addr,
  input  logic                        src_a_vec,
  input  logic                        src_b_vec,
  output logic                        conv_hazard,
  output logic                        stall_req,
  output logic                        vreg_we,
  output logic [AW-1:0]               vreg_waddr,
  output logic [VW-1:0]               vreg_wdata,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
  output logic                        overflow_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);

  logic                w_full;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_count_next;
  logic [AW-1:0]       w_head_addr;
  logic [VW-1:0]       w_head_data;
  logic [DEPTH*AW-1:0] w_entry_addr;
  logic [DEPTH-1:0]    w_entry_valid;
  logic                w_push;
  logic                w_pop;
  logic [SW-1:0]       w_starve_next;
  logic                w_hazard;
  grant_e              w_grant;

  logic                r_we;
  logic                r_is_conv;
  logic [AW-1:0]       r_waddr;
  logic [VW-1:0]       r_wdata;
  logic [SW-1:0]       r_starve;
  logic                r_stall;
  logic                r_ovf;

  assign w_push       = conv_valid && !w_full;
  assign w_pop        = !wb_valid && (w_count != '0);
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  conv_wb_fifo #(.AW(AW), .VW(VW), .DEPTH(DEPTH)) u_fifo (
    .i_clk         (clk),
    .i_reset_n     (reset),
    .i_push        (w_push),
    .i_addr        (conv_addr),
    .i_data        (conv_data),
    .i_pop         (w_pop),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_entry_addr  (w_entry_addr),
    .o_entry_valid (w_entry_valid)
  );

  always_comb begin
    w_grant = GRANT_IDLE;
    if (wb_valid)             w_grant = GRANT_WB;
    else if (w_count != '0)   w_grant = GRANT_CONV;
  end

  // Starvation only accumulates while wb keeps beating a non-empty buffer.
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || (w_count == '0))
      w_starve_next = '0;
    else if (wb_valid && (r_starve != SW'(STARVE_MAX)))
      w_starve_next = r_starve + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_is_conv <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_starve  <= '0;
      r_stall   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (w_grant)
        GRANT_WB: begin
          r_we      <= 1'b1;
          r_is_conv <= 1'b0;
          r_waddr   <= wb_addr;
          r_wdata   <= wb_data;
        end
        GRANT_CONV: begin
          r_we      <= 1'b1;
          r_is_conv <= 1'b1;
          r_waddr   <= w_head_addr;
          r_wdata   <= w_head_data;
        end
        default: begin
          r_we      <= 1'b0;
          r_is_conv <= 1'b0;
        end
      endcase
      r_starve <= w_starve_next;
      r_stall  <= (w_count_next >= CW'(DEPTH-1)) || (w_starve_next == SW'(STARVE_MAX));
      if (conv_valid && w_full) r_ovf <= 1'b1;
    end
  end

  // Pending conv destinations: queued entries, the write in flight, and this cycle's push.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i] &&
          src_hit(src_a_vec, src_a_addr == w_entry_addr[i*AW +: AW],
                  src_b_vec, src_b_addr == w_entry_addr[i*AW +: AW]))
        w_hazard = 1'b1;
    end
    if (r_we && r_is_conv &&
        src_hit(src_a_vec, src_a_addr == r_waddr, src_b_vec, src_b_addr == r_waddr))
      w_hazard = 1'b1;
    if (w_push &&
        src_hit(src_a_vec, src_a_addr == conv_addr, src_b_vec, src_b_addr == conv_addr))
      w_hazard = 1'b1;
  end

  assign conv_ready   = !w_full;
  assign conv_hazard  = w_hazard;
  assign stall_req    = r_stall;
  assign vreg_we      = r_we;
  assign vreg_waddr   = r_waddr;
  assign vreg_wdata   = r_wdata;
  assign fifo_count   = w_count;
  assign overflow_err = r_ovf;

endmodule
